// File: rtl/gate_truth_table_checker_pkg.sv
// rtl/gate_truth_table_checker_pkg.sv - shared state encodings and widths for the truth-table checker
package gate_truth_table_checker_pkg;

   localparam int GTC_CNT_W = 8;

   typedef enum logic [1:0] {
      GTC_IDLE   = 2'd0,
      GTC_SETTLE = 2'd1,
      GTC_SAMPLE = 2'd2,
      GTC_DONE   = 2'd3
   } gtc_state_e;

   // Reload value so that SETTLE state lasts exactly `settle` cycles.
   function automatic logic [GTC_CNT_W-1:0] settle_reload(input int settle);
      return GTC_CNT_W'(settle - 1);
   endfunction

endpackage

// File: rtl/gtc_settle_timer.sv
// rtl/gtc_settle_timer.sv - settle down-counter; expired while the count sits at zero
module gtc_settle_timer
   import gate_truth_table_checker_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic [GTC_CNT_W-1:0] value,
   output logic                 expired
);

   logic [GTC_CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= value;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/gate_truth_table_checker.sv
// rtl/gate_truth_table_checker.sv - sweeps all input vectors of a small gate and compares against a truth table
module gate_truth_table_checker
   import gate_truth_table_checker_pkg::*;
#(
   parameter int                   N_IN   = 2,
   parameter int                   SETTLE = 4,
   parameter logic [(1<<N_IN)-1:0] EXPECT = 4'b1000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic [N_IN-1:0]        dut_in,
   input  logic                   dut_out,
   output logic                   busy,
   output logic                   done,
   output logic                   valid,
   output logic                   pass,
   output logic [(1<<N_IN)-1:0]   fail_mask,
   output logic [N_IN-1:0]        vec_idx
);

   localparam int              N_VEC    = 1 << N_IN;
   localparam logic [N_IN-1:0] LAST_VEC = N_IN'(N_VEC - 1);

   gtc_state_e        state, state_nx;
   logic              accept, timer_load, timer_expired;
   logic              sample, advance, finish, clear_vec;
   logic [N_VEC-1:0]  sample_mask;

   gtc_settle_timer u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (timer_load),
      .value   (settle_reload(SETTLE)),
      .expired (timer_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= GTC_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      accept     = 1'b0;
      timer_load = 1'b0;
      sample     = 1'b0;
      advance    = 1'b0;
      finish     = 1'b0;
      clear_vec  = 1'b0;
      case (state)
         GTC_IDLE: begin
            if (start) begin
               accept     = 1'b1;
               timer_load = 1'b1;
               state_nx   = GTC_SETTLE;
            end
         end
         GTC_SETTLE: begin
            if (timer_expired) begin
               state_nx = GTC_SAMPLE;
            end
         end
         GTC_SAMPLE: begin
            sample = 1'b1;
            if (vec_idx == LAST_VEC) begin
               finish   = 1'b1;
               state_nx = GTC_DONE;
            end else begin
               advance    = 1'b1;
               timer_load = 1'b1;
               state_nx   = GTC_SETTLE;
            end
         end
         GTC_DONE: begin
            clear_vec = 1'b1;
            state_nx  = GTC_IDLE;
         end
         default: state_nx = GTC_IDLE;
      endcase
   end

   // Mask including the vector being sampled now, so pass can settle with done.
   always_comb begin
      sample_mask          = fail_mask;
      sample_mask[vec_idx] = (dut_out != EXPECT[vec_idx]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_idx   <= '0;
         fail_mask <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         valid     <= 1'b0;
         pass      <= 1'b0;
      end else begin
         done <= finish;
         if (accept) begin
            vec_idx   <= '0;
            fail_mask <= '0;
            valid     <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b1;
         end
         if (sample) begin
            fail_mask <= sample_mask;
         end
         if (advance) begin
            vec_idx <= vec_idx + 1'b1;
         end
         if (finish) begin
            valid <= 1'b1;
            pass  <= ~|sample_mask;
            busy  <= 1'b0;
         end
         if (clear_vec) begin
            vec_idx <= '0;
         end
      end
   end

   assign dut_in = vec_idx;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// tb/tb_gate_truth_table_checker.sv - scoreboard bench for gate_truth_table_checker
module tb_gate_truth_table_checker;

   localparam int SET0 = 4;
   localparam int VEC_CYC = SET0 + 1;
   localparam int SWEEP = 4 * VEC_CYC;
   localparam logic [3:0] EXP0 = 4'b1000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] dut_in, vec_idx;
   logic       dut_out, busy, done, valid, pass;
   logic [3:0] fail_mask;
   logic [3:0] dut_tt = 4'b1000;

   logic       start1 = 1'b0;
   logic [0:0] dut_in1, vec_idx1;
   logic       dut_out1, busy1, done1, valid1, pass1;
   logic [1:0] fail_mask1;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0] mask;
      logic       pass;
      int         e0;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign dut_out  = dut_tt[dut_in];
   assign dut_out1 = ~dut_in1[0];

   gate_truth_table_checker #(.N_IN(2), .SETTLE(SET0), .EXPECT(EXP0)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_out(dut_out),
      .busy(busy), .done(done), .valid(valid), .pass(pass),
      .fail_mask(fail_mask), .vec_idx(vec_idx)
   );

   gate_truth_table_checker #(.N_IN(1), .SETTLE(1), .EXPECT(2'b01)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .dut_in(dut_in1), .dut_out(dut_out1),
      .busy(busy1), .done(done1), .valid(valid1), .pass(pass1),
      .fail_mask(fail_mask1), .vec_idx(vec_idx1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [3:0] gate_tt(input int kind);
      logic [3:0] tt;
      for (int i = 0; i < 4; i++) begin
         int a = (i >> 1) & 1;
         int b = i & 1;
         tt[i] = (kind == 0) ? logic'(a & b) : logic'(a | b);
      end
      return tt;
   endfunction

   function automatic exp_t model(input logic [3:0] tt, input int e0);
      exp_t e;
      e.mask = '0;
      for (int i = 0; i < 4; i++) e.mask[i] = (tt[i] != EXP0[i]);
      e.pass = (e.mask == 4'b0000);
      e.e0   = e0;
      return e;
   endfunction

   // Monitor: timing, stimulus order and results of the sweep at the scoreboard head.
   always @(negedge clk) begin
      if (rst_n) begin
         if (sb.size() > 0) begin
            int off;
            off = cyc - sb[0].e0;
            if (off >= 0 && off < SWEEP) begin
               chk("busy_during_sweep", 32'(busy), 32'd1);
               chk("dut_in_order", 32'(dut_in), 32'(off / VEC_CYC));
               chk("vec_idx_eq_dut_in", 32'(vec_idx), 32'(dut_in));
               if (done) chk("early_done", 32'(done), 32'd0);
            end else if (off == SWEEP) begin
               chk("done_at_e0_plus_sweep", 32'(done), 32'd1);
               chk("valid_with_done", 32'(valid), 32'd1);
               chk("pass", 32'(pass), 32'(sb[0].pass));
               chk("fail_mask", 32'(fail_mask), 32'(sb[0].mask));
               chk("busy_low_at_done", 32'(busy), 32'd0);
               void'(sb.pop_front());
            end
         end else if (done) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end
      end
   end

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   // Called at a negedge with the checker idle; returns at a negedge with it idle again.
   task automatic run_sweep(input logic [3:0] tt, input bit repulse);
      exp_t e;
      dut_tt = tt;
      start  = 1'b1;
      e = model(tt, cyc + 1);
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      if (repulse) begin
         repeat (6) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_done("sweep");
      if (repulse) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("dut_in_zero_after", 32'(dut_in), 32'd0);
      chk("busy_low_after", 32'(busy), 32'd0);
      if (repulse) begin
         repeat (3) @(negedge clk);
         chk("valid_held", 32'(valid), 32'd1);
         chk("mask_held", 32'(fail_mask), 32'(e.mask));
         chk("no_restart", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      exp_t e;
      int e0;
      int n;

      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_mask", 32'(fail_mask), 32'd0);
      chk("rst_dut_in", 32'(dut_in), 32'd0);
      chk("rst1_busy", 32'(busy1), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_sweep(gate_tt(0), 1'b0);
      run_sweep(gate_tt(1), 1'b0);
      run_sweep(gate_tt(0), 1'b1);

      // Reset mid-sweep with a partial mismatch already recorded.
      dut_tt = gate_tt(1);
      start  = 1'b1;
      e0 = cyc + 1;
      sb.push_back(model(dut_tt, e0));
      @(negedge clk);
      start = 1'b0;
      while (cyc < e0 + 10) @(negedge clk);
      #2;
      rst_n = 1'b0;
      void'(sb.pop_back());
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_dut_in", 32'(dut_in), 32'd0);
      chk("abort_mask", 32'(fail_mask), 32'd0);
      chk("abort_valid", 32'(valid), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_sweep(gate_tt(1), 1'b0);

      for (int k = 0; k < 8; k++) begin
         run_sweep(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // Single-input instance with inverter DUT, then back-to-back rerun.
      start1 = 1'b1;
      e0 = cyc + 1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (!done1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("inv_done_time", 32'(cyc - e0), 32'd4);
      chk("inv_done", 32'(done1), 32'd1);
      chk("inv_pass", 32'(pass1), 32'd1);
      chk("inv_valid", 32'(valid1), 32'd1);
      chk("inv_mask", 32'(fail_mask1), 32'd0);
      @(negedge clk);
      start1 = 1'b1;
      e0 = cyc + 1;
      @(negedge clk);
      start1 = 1'b0;
      chk("inv_rerun_valid_clr", 32'(valid1), 32'd0);
      chk("inv_rerun_busy", 32'(busy1), 32'd1);
      chk("inv_rerun_vec", 32'(vec_idx1), 32'(dut_in1));
      n = 0;
      while (!done1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("inv_rerun_done_time", 32'(cyc - e0), 32'd4);
      chk("inv_rerun_pass", 32'(pass1), 32'd1);

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
